tl2ahb_bridge: RTL and testbench

TL2AHB_BRIDGE -- requirements
Module: tl2ahb_bridge

---
 rtl/tl2ahb_bridge_if.sv | 53 +++++
 rtl/tl2ahb_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_tl2ahb_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl2ahb_bridge_if.sv
// TL-UL A/D channels and AHB-Lite manager bus of the TL-UL to AHB-Lite bridge.
// master modport is the bridge side; slave modport is the TL host / AHB subordinate side.
interface tl2ahb_bridge_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [2:0]            d_size;
    logic [SRC_W-1:0]      d_source;
    logic [DATA_W-1:0]     d_data;
    logic                  d_denied;

    logic [ADDR_W-1:0]     haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_W-1:0]     hwdata;
    logic [DATA_W-1:0]     hrdata;
    logic                  hready;
    logic                  hresp;

    modport master (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        input  d_ready,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        output d_ready,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/tl2ahb_bridge.sv
// TL-UL to AHB-Lite bridge: pipelined single transfers, in-order response FIFO with credits.
// Define TL2AHB_TIMEOUT_EN to add the data-phase watchdog (limit TIMEOUT_CYC cycles).
module tl2ahb_bridge #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int SRC_W       = 4,
    parameter int RESP_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input logic              clock,
    input logic              reset_n,
    tl2ahb_bridge_if.master  bus
);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int PTR_W    = $clog2(RESP_DEPTH);
    localparam int FCNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int CNT_W    = $clog2(RESP_DEPTH + 3);

    typedef enum logic [2:0] {
        TL_PUT_FULL    = 3'd0,
        TL_PUT_PARTIAL = 3'd1,
        TL_GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_ACCESS_ACK      = 3'd0,
        TL_ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        size;
        logic [SRC_W-1:0]  source;
        logic [DATA_W-1:0] data;
        logic              denied;
    } resp_t;

    // Address-phase and data-phase holding registers
    logic              ap_valid, ap_write;
    logic [ADDR_W-1:0] ap_addr;
    logic [2:0]        ap_size;
    logic [SRC_W-1:0]  ap_source;
    logic [DATA_W-1:0] ap_wdata;
    logic              dp_valid, dp_write;
    logic [2:0]        dp_size;
    logic [SRC_W-1:0]  dp_source;
    logic [DATA_W-1:0] dp_wdata;
    logic              ready_en;

    resp_t             mem [RESP_DEPTH];
    resp_t             head, push_entry;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              push, pop, wr_en;

    logic              bus_busy, err, idle, op_ok, bad_beat, credit_ok;
    logic              accept, addr_adv, dp_done, timeout_hit, to_wait;
    logic [CNT_W-1:0]  used;
    logic              unused_ok;

    assign unused_ok = ^{bus.a_mask, TIMEOUT_CYC == 0};

    assign bus_busy  = dp_valid || to_wait;
    assign err       = bus_busy && bus.hresp;
    assign idle      = !ap_valid && !bus_busy;
    assign op_ok     = (bus.a_opcode == TL_GET) || (bus.a_opcode == TL_PUT_FULL) ||
                       (bus.a_opcode == TL_PUT_PARTIAL);
    assign bad_beat  = !op_ok || (bus.a_size > 3'(MAX_SIZE));
    assign used      = CNT_W'(fifo_cnt) + CNT_W'(ap_valid) + CNT_W'(dp_valid);
    assign credit_ok = used < CNT_W'(RESP_DEPTH);

    assign bus.a_ready = ready_en && credit_ok && (!ap_valid || bus.hready) && !err &&
                         !to_wait && (!bad_beat || idle);
    assign accept      = bus.a_valid && bus.a_ready;
    assign addr_adv    = ap_valid && bus.hready && !err;
    assign dp_done     = dp_valid && bus.hready;

    // htrans drops to IDLE combinationally on hresp so the pipelined address is
    // cancelled in the first ERROR cycle; it stays queued in ap_* for re-issue.
    assign bus.htrans = (ap_valid && !err) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr  = ap_addr;
    assign bus.hwrite = ap_write;
    assign bus.hsize  = ap_size;
    assign bus.hburst = 3'b000;
    assign bus.hprot  = 4'b0011;
    assign bus.hwdata = bus_busy ? dp_wdata : '0;

`ifdef TL2AHB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_wait_q;

    assign timeout_hit = dp_valid && !bus.hready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign to_wait     = to_wait_q;

    // After a timeout the subordinate still owes hready; that completion is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt    <= '0;
            to_wait_q <= 1'b0;
        end else begin
            if (dp_valid && !bus.hready && !timeout_hit)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
            if (timeout_hit)
                to_wait_q <= 1'b1;
            else if (bus.hready)
                to_wait_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_wait     = 1'b0;
`endif

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (dp_done) begin
            push              = 1'b1;
            push_entry.opcode = dp_write ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
            push_entry.size   = dp_size;
            push_entry.source = dp_source;
            push_entry.denied = bus.hresp;
            push_entry.data   = (dp_write || bus.hresp) ? '0 : bus.hrdata;
        end else if (timeout_hit) begin
            push              = 1'b1;
            push_entry.opcode = dp_write ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;
            push_entry.size   = dp_size;
            push_entry.source = dp_source;
            push_entry.denied = 1'b1;
        end else if (accept && bad_beat) begin
            push              = 1'b1;
            push_entry.opcode = (bus.a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
            push_entry.size   = bus.a_size;
            push_entry.source = bus.a_source;
            push_entry.denied = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en  <= 1'b0;
            ap_valid  <= 1'b0;
            ap_write  <= 1'b0;
            ap_addr   <= '0;
            ap_size   <= '0;
            ap_source <= '0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_size   <= '0;
            dp_source <= '0;
            dp_wdata  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (dp_done || timeout_hit)
                dp_valid <= 1'b0;
            if (addr_adv) begin
                dp_valid  <= 1'b1;
                dp_write  <= ap_write;
                dp_size   <= ap_size;
                dp_source <= ap_source;
                dp_wdata  <= ap_wdata;
                ap_valid  <= 1'b0;
            end
            if (accept && !bad_beat) begin
                ap_valid  <= 1'b1;
                ap_write  <= (bus.a_opcode != TL_GET);
                ap_addr   <= bus.a_address;
                ap_size   <= bus.a_size;
                ap_source <= bus.a_source;
                ap_wdata  <= bus.a_data;
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop   = bus.d_valid && bus.d_ready;
    assign wr_en = push && ((fifo_cnt != FCNT_W'(RESP_DEPTH)) || pop);

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign bus.d_valid  = (fifo_cnt != '0);
    assign bus.d_opcode = head.opcode;
    assign bus.d_size   = head.size;
    assign bus.d_source = head.source;
    assign bus.d_data   = bus.d_valid ? head.data : '0;
    assign bus.d_denied = bus.d_valid && head.denied;
endmodule

// File: tb/tb_tl2ahb_bridge.sv
// Directed self-checking bench for tl2ahb_bridge (RESP_DEPTH=4, TIMEOUT_CYC=8).
// The watchdog scenario is compiled only when TL2AHB_TIMEOUT_EN is defined.
module tb_tl2ahb_bridge;
    logic clock;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [29:0] tb_dp_addr;

    tl2ahb_bridge_if #(.ADDR_W(30), .DATA_W(32), .SRC_W(4)) bus ();

    tl2ahb_bridge #(
        .ADDR_W(30), .DATA_W(32), .SRC_W(4), .RESP_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Minimal subordinate model: remembers the address accepted for the next data phase
    always @(posedge clock)
        if (bus.hready && bus.htrans == 2'd2)
            tb_dp_addr <= bus.haddr;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                           input logic [29:0] addr, input logic [31:0] data);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_size    = sz;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = 4'hf;
        bus.a_data    = data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_opcode = 3'd4; bus.a_size = 3'd2; bus.a_source = '0;
        bus.a_address = '0; bus.a_mask = 4'hf; bus.a_data = '0; bus.d_ready = 1'b0;
        bus.hrdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL rst_htrans got=%0h want=0", bus.htrans); end
        n_cmp++; if (bus.haddr !== 30'h0) begin n_bad++; $display("FAIL rst_haddr got=%0h want=0", bus.haddr); end
        n_cmp++; if (bus.hwrite !== 1'b0) begin n_bad++; $display("FAIL rst_hwrite got=%0b want=0", bus.hwrite); end
        n_cmp++; if (bus.hsize !== 3'd0) begin n_bad++; $display("FAIL rst_hsize got=%0h want=0", bus.hsize); end
        n_cmp++; if (bus.hburst !== 3'd0) begin n_bad++; $display("FAIL rst_hburst got=%0h want=0", bus.hburst); end
        n_cmp++; if (bus.hprot !== 4'b0011) begin n_bad++; $display("FAIL rst_hprot got=%0h want=3", bus.hprot); end
        n_cmp++; if (bus.hwdata !== 32'h0) begin n_bad++; $display("FAIL rst_hwdata got=%0h want=0", bus.hwdata); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready got=%0b want=0", bus.a_ready); end
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid got=%0b want=0", bus.d_valid); end
        n_cmp++; if (bus.d_denied !== 1'b0) begin n_bad++; $display("FAIL rst_d_denied got=%0b want=0", bus.d_denied); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL rel_a_ready_early got=%0b want=0", bus.a_ready); end
        step();
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL rel_a_ready got=%0b want=1", bus.a_ready); end
    endtask

    task automatic test_get();
        step();
        drive_a(3'd4, 3'd2, 4'd3, 30'h100, 32'h0);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL get_a_ready got=%0b want=1", bus.a_ready); end
        step();
        bus.a_valid = 1'b0;
        #1;
        n_cmp++; if (bus.htrans !== 2'd2) begin n_bad++; $display("FAIL get_htrans got=%0h want=2", bus.htrans); end
        n_cmp++; if (bus.haddr !== 30'h100) begin n_bad++; $display("FAIL get_haddr got=%0h want=100", bus.haddr); end
        n_cmp++; if (bus.hwrite !== 1'b0) begin n_bad++; $display("FAIL get_hwrite got=%0b want=0", bus.hwrite); end
        n_cmp++; if (bus.hsize !== 3'd2) begin n_bad++; $display("FAIL get_hsize got=%0h want=2", bus.hsize); end
        step();
        bus.hrdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL get_htrans_idle got=%0h want=0", bus.htrans); end
        step();
        bus.hrdata = '0;
        #1;
        n_cmp++; if (bus.d_valid !== 1'b1) begin n_bad++; $display("FAIL get_d_valid got=%0b want=1", bus.d_valid); end
        n_cmp++; if (bus.d_opcode !== 3'd1) begin n_bad++; $display("FAIL get_d_opcode got=%0h want=1", bus.d_opcode); end
        n_cmp++; if (bus.d_source !== 4'd3) begin n_bad++; $display("FAIL get_d_source got=%0h want=3", bus.d_source); end
        n_cmp++; if (bus.d_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL get_d_data got=%0h want=deadbeef", bus.d_data); end
        n_cmp++; if (bus.d_denied !== 1'b0) begin n_bad++; $display("FAIL get_d_denied got=%0b want=0", bus.d_denied); end
        bus.d_ready = 1'b1;
        step();
        bus.d_ready = 1'b0;
        #1;
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL get_pop got=%0b want=0", bus.d_valid); end
    endtask

    task automatic test_back_to_back();
        step();
        drive_a(3'd0, 3'd2, 4'd1, 30'h0, 32'h11111111);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready0 got=%0b want=1", bus.a_ready); end
        step();
        drive_a(3'd0, 3'd2, 4'd2, 30'h4, 32'h22222222);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_ready1 got=%0b want=1", bus.a_ready); end
        n_cmp++; if (bus.hwrite !== 1'b1) begin n_bad++; $display("FAIL b2b_hwrite got=%0b want=1", bus.hwrite); end
        step();
        bus.a_valid = 1'b0;
        #1;
        n_cmp++; if (bus.htrans !== 2'd2) begin n_bad++; $display("FAIL b2b_overlap_htrans got=%0h want=2", bus.htrans); end
        n_cmp++; if (bus.haddr !== 30'h4) begin n_bad++; $display("FAIL b2b_overlap_haddr got=%0h want=4", bus.haddr); end
        n_cmp++; if (bus.hwdata !== 32'h11111111) begin n_bad++; $display("FAIL b2b_hwdata0 got=%0h want=11111111", bus.hwdata); end
        step();
        #1;
        n_cmp++; if (bus.hwdata !== 32'h22222222) begin n_bad++; $display("FAIL b2b_hwdata1 got=%0h want=22222222", bus.hwdata); end
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL b2b_htrans_idle got=%0h want=0", bus.htrans); end
        step();
        bus.d_ready = 1'b1;
        #1;
        n_cmp++; if (bus.d_source !== 4'd1 || bus.d_opcode !== 3'd0) begin n_bad++; $display("FAIL b2b_first got=src%0h/op%0h want=src1/op0", bus.d_source, bus.d_opcode); end
        step();
        #1;
        n_cmp++; if (bus.d_source !== 4'd2 || bus.d_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second got=src%0h/v%0b want=src2/v1", bus.d_source, bus.d_valid); end
        step();
        bus.d_ready = 1'b0;
        #1;
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got=%0b want=0", bus.d_valid); end
    endtask

    task automatic test_error();
        step();
        drive_a(3'd4, 3'd2, 4'd5, 30'h200, 32'h0);
        step();
        drive_a(3'd0, 3'd2, 4'd6, 30'h204, 32'hA5A5A5A5);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL err_put_accept got=%0b want=1", bus.a_ready); end
        step();
        bus.a_valid = 1'b0; bus.hready = 1'b0; bus.hresp = 1'b1; bus.hrdata = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL err_cycle1_htrans got=%0h want=0", bus.htrans); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL err_a_ready got=%0b want=0", bus.a_ready); end
        step();
        bus.hready = 1'b1;
        #1;
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL err_cycle2_htrans got=%0h want=0", bus.htrans); end
        step();
        bus.hresp = 1'b0; bus.hrdata = '0;
        #1;
        n_cmp++; if (bus.htrans !== 2'd2 || bus.haddr !== 30'h204 || bus.hwrite !== 1'b1) begin n_bad++; $display("FAIL err_reissue got=%0h/%0h/%0b want=2/204/1", bus.htrans, bus.haddr, bus.hwrite); end
        n_cmp++; if (bus.d_denied !== 1'b1) begin n_bad++; $display("FAIL err_denied got=%0b want=1", bus.d_denied); end
        n_cmp++; if (bus.d_data !== 32'h0) begin n_bad++; $display("FAIL err_d_data got=%0h want=0", bus.d_data); end
        n_cmp++; if (bus.d_source !== 4'd5 || bus.d_opcode !== 3'd1) begin n_bad++; $display("FAIL err_d_id got=src%0h/op%0h want=src5/op1", bus.d_source, bus.d_opcode); end
        step();
        #1;
        n_cmp++; if (bus.hwdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL err_put_hwdata got=%0h want=a5a5a5a5", bus.hwdata); end
        step();
        bus.d_ready = 1'b1;
        step();
        #1;
        n_cmp++; if (bus.d_source !== 4'd6 || bus.d_denied !== 1'b0 || bus.d_opcode !== 3'd0) begin n_bad++; $display("FAIL err_put_ack got=src%0h/den%0b/op%0h want=src6/den0/op0", bus.d_source, bus.d_denied, bus.d_opcode); end
        step();
        bus.d_ready = 1'b0;
        #1;
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL err_drained got=%0b want=0", bus.d_valid); end
    endtask

    task automatic test_credits();
        int sent = 0;
        int got  = 0;
        step();
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            if (sent < 6) drive_a(3'd4, 3'd2, 4'(sent), 30'(sent * 'h40), 32'h0);
            else bus.a_valid = 1'b0;
            bus.hrdata = 32'hA000_0000 | 32'(tb_dp_addr);
            if (cyc == 10) bus.d_ready = 1'b1;
            #1;
            if (cyc == 3) begin
                n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL cred_4th_ready got=%0b want=1", bus.a_ready); end
            end
            if (cyc == 7) begin
                n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL cred_stall got=%0b want=0", bus.a_ready); end
                n_cmp++; if (sent !== 4) begin n_bad++; $display("FAIL cred_accepted got=%0d want=4", sent); end
            end
            if (bus.d_valid && bus.d_ready) begin
                n_cmp++;
                if (bus.d_source !== 4'(got) || bus.d_data !== (32'hA000_0000 | 32'(got * 'h40))) begin
                    n_bad++;
                    $display("FAIL cred_resp%0d got=src%0h/%0h want=src%0h/%0h", got, bus.d_source, bus.d_data, got, 32'hA000_0000 | 32'(got * 'h40));
                end
                got++;
            end
            if (bus.a_valid && bus.a_ready) sent++;
            step();
        end
        bus.a_valid = 1'b0; bus.d_ready = 1'b0; bus.hrdata = '0;
        n_cmp++; if (got != 6) begin n_bad++; $display("FAIL cred_all_done got=%0d want=6", got); end
    endtask

    task automatic test_bad_op();
        step();
        drive_a(3'd4, 3'd2, 4'd1, 30'h300, 32'h0);
        step();
        drive_a(3'd4, 3'd3, 4'd2, 30'h308, 32'h0);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL bad_inflight_ap got=%0b want=0", bus.a_ready); end
        step();
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL bad_inflight_dp got=%0b want=0", bus.a_ready); end
        step();
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL bad_idle_ready got=%0b want=1", bus.a_ready); end
        step();
        bus.a_valid = 1'b0; bus.d_ready = 1'b1;
        #1;
        n_cmp++; if (bus.htrans !== 2'd0) begin n_bad++; $display("FAIL bad_no_ahb got=%0h want=0", bus.htrans); end
        n_cmp++; if (bus.d_source !== 4'd1 || bus.d_denied !== 1'b0) begin n_bad++; $display("FAIL bad_first got=src%0h/den%0b want=src1/den0", bus.d_source, bus.d_denied); end
        step();
        #1;
        n_cmp++; if (bus.d_source !== 4'd2 || bus.d_denied !== 1'b1 || bus.d_size !== 3'd3) begin n_bad++; $display("FAIL bad_size_resp got=src%0h/den%0b/sz%0h want=src2/den1/sz3", bus.d_source, bus.d_denied, bus.d_size); end
        step();
        bus.d_ready = 1'b0;
        drive_a(3'd2, 3'd2, 4'd9, 30'h310, 32'h0);
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1 || bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL bad_op_ready got=rdy%0b/v%0b want=rdy1/v0", bus.a_ready, bus.d_valid); end
        step();
        bus.a_valid = 1'b0;
        #1;
        n_cmp++; if (bus.d_denied !== 1'b1 || bus.d_source !== 4'd9 || bus.htrans !== 2'd0) begin n_bad++; $display("FAIL bad_op_resp got=den%0b/src%0h/ht%0h want=den1/src9/ht0", bus.d_denied, bus.d_source, bus.htrans); end
        bus.d_ready = 1'b1;
        step();
        bus.d_ready = 1'b0;
    endtask

`ifdef TL2AHB_TIMEOUT_EN
    task automatic test_timeout();
        step();
        drive_a(3'd4, 3'd2, 4'd4, 30'h400, 32'h0);
        step();
        bus.a_valid = 1'b0;
        step();
        bus.hready = 1'b0;
        repeat (7) step();
        #1;
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL to_early got=%0b want=0", bus.d_valid); end
        step();
        #1;
        n_cmp++; if (bus.d_valid !== 1'b1 || bus.d_denied !== 1'b1 || bus.d_source !== 4'd4) begin n_bad++; $display("FAIL to_resp got=v%0b/den%0b/src%0h want=v1/den1/src4", bus.d_valid, bus.d_denied, bus.d_source); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL to_hold0 got=%0b want=0", bus.a_ready); end
        step();
        bus.hready = 1'b1;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL to_hold1 got=%0b want=0", bus.a_ready); end
        step();
        bus.d_ready = 1'b1;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL to_release got=%0b want=1", bus.a_ready); end
        step();
        bus.d_ready = 1'b0;
        #1;
        n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL to_late_discard got=%0b want=0", bus.d_valid); end
    endtask
`endif

    task automatic test_reset_mid();
        step();
        drive_a(3'd0, 3'd2, 4'd7, 30'h8, 32'h77);
        step();
        bus.a_valid = 1'b0;
        step();
        bus.hready = 1'b0;
        #1;
        n_cmp++; if (bus.hwdata !== 32'h77) begin n_bad++; $display("FAIL rm_hwdata got=%0h want=77", bus.hwdata); end
        step();
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.htrans !== 2'd0 || bus.haddr !== 30'h0 || bus.hwrite !== 1'b0 || bus.hsize !== 3'd0) begin n_bad++; $display("FAIL rm_addr_regs got=%0h/%0h/%0b/%0h want=0/0/0/0", bus.htrans, bus.haddr, bus.hwrite, bus.hsize); end
        n_cmp++; if (bus.hwdata !== 32'h0 || bus.hprot !== 4'b0011 || bus.hburst !== 3'd0) begin n_bad++; $display("FAIL rm_misc got=%0h/%0h/%0h want=0/3/0", bus.hwdata, bus.hprot, bus.hburst); end
        n_cmp++; if (bus.a_ready !== 1'b0 || bus.d_valid !== 1'b0 || bus.d_denied !== 1'b0) begin n_bad++; $display("FAIL rm_tl got=%0b/%0b/%0b want=0/0/0", bus.a_ready, bus.d_valid, bus.d_denied); end
        bus.hready = 1'b1;
        step();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready_early got=%0b want=0", bus.a_ready); end
        step();
        #1;
        n_cmp++; if (bus.a_ready !== 1'b1 || bus.d_valid !== 1'b0 || bus.htrans !== 2'd0) begin n_bad++; $display("FAIL rm_after got=rdy%0b/v%0b/ht%0h want=rdy1/v0/ht0", bus.a_ready, bus.d_valid, bus.htrans); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_get();
        test_back_to_back();
        test_error();
        test_credits();
        test_bad_op();
`ifdef TL2AHB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
